md_issue_queue: RTL

- Request buffer directly upstream of the HI/LO multiply/divide unit.
- The E stage pushes mult/multu/div/divu requests. The block holds them in a small FIFO and launches each one as a single start pulse only when the unit is idle.
- An in-flight operation is therefore never restarted.
- Also provides the stall signal for HI/LO access instructions (mfhi/mflo/mthi/mtlo) while any multiply/divide work is pending.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_req_fifo.sv | 62 ++++++
 rtl/md_issue_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the HI/LO multiply/divide issue queue.
//   - op encodings (bit 2 set marks an invalid request)
//   - issue FSM state encoding
//   - request record carried through the FIFO (op + rs + rt = 67 bits)
package md_pkg;

   localparam int MD_REQ_W = 3 + 32 + 32;

   typedef enum logic [2:0] {
      MD_MULT  = 3'b000,
      MD_MULTU = 3'b001,
      MD_DIV   = 3'b010,
      MD_DIVU  = 3'b011
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } md_state_e;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } md_req_t;

   function automatic logic md_op_valid(input logic [2:0] op);
      return !op[2];
   endfunction

endpackage

// File: rtl/md_req_fifo.sv
// md_req_fifo: generic DEPTH-entry synchronous FIFO with occupancy count.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (clears pointers/count)
//   i_push   in   write i_wdata at the edge (ignored when full)
//   i_wdata  in   W-bit write data
//   i_pop    in   advance read pointer at the edge (ignored when empty)
//   o_rdata  out  head entry (valid when o_count != 0)
//   o_count  out  PTR_W+1 bit entry count
module md_req_fifo
   import md_pkg::*;
#(
   parameter  int DEPTH = 4,
   parameter  int W     = MD_REQ_W,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [W-1:0]     i_wdata,
   input  logic             i_pop,
   output logic [W-1:0]     o_rdata,
   output logic [PTR_W:0]   o_count
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [W-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && (r_count != FULL_CNT);
   assign w_pop   = i_pop  && (r_count != '0);
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Storage is not reset; contents are only observed through the count.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/md_issue_queue.sv
// md_issue_queue: request buffer in front of the HI/LO multiply/divide unit.
// Buffers mult/multu/div/divu requests and launches each as a single
// md_start pulse only while the unit is idle; stalls HI/LO accesses while
// any multiply/divide work is queued or in flight.
// Optional feature macro: MD_ISSUE_BYPASS_EN -- when defined, a request
// arriving with the queue empty, FSM idle and unit idle skips the FIFO and
// launches one cycle after enqueue instead of two.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   enq_valid   in   E-stage request present
//   enq_op      in   3-bit op (bit 2 set = invalid, dropped)
//   enq_a/b     in   32-bit operands rs/rt
//   enq_ready   out  queue has a free slot (from count only)
//   md_busy     in   unit busy flag
//   md_start    out  one-cycle launch pulse
//   md_op/a/b   out  launched request, held stable between launches
//   hilo_req    in   mfhi/mflo/mthi/mtlo present in D/E
//   hilo_stall  out  stall the HI/LO access
//   occupancy   out  queued entry count
module md_issue_queue
   import md_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_valid,
   input  logic [2:0]       enq_op,
   input  logic [31:0]      enq_a,
   input  logic [31:0]      enq_b,
   output logic             enq_ready,
   input  logic             md_busy,
   output logic             md_start,
   output logic [2:0]       md_op,
   output logic [31:0]      md_a,
   output logic [31:0]      md_b,
   input  logic             hilo_req,
   output logic             hilo_stall,
   output logic [PTR_W:0]   occupancy
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   md_state_e r_state;
   logic      r_start;
   md_req_t   r_req;

   md_req_t        w_enq_req;
   md_req_t        w_head_req;
   logic [PTR_W:0] w_count;
   logic           w_accept;
   logic           w_bypass;
   logic           w_push;
   logic           w_pop;

   assign w_enq_req = '{op: enq_op, a: enq_a, b: enq_b};
   assign enq_ready = (w_count != FULL_CNT);
   assign w_accept  = enq_valid && enq_ready && md_op_valid(enq_op);

`ifdef MD_ISSUE_BYPASS_EN
   assign w_bypass = w_accept && (r_state == ST_IDLE) && (w_count == '0) && !md_busy;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_push = w_accept && !w_bypass;
   assign w_pop  = (r_state == ST_IDLE) && (w_count != '0) && !md_busy;

   md_req_fifo #(
      .DEPTH (DEPTH),
      .W     (MD_REQ_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_wdata (w_enq_req),
      .i_pop   (w_pop),
      .o_rdata (w_head_req),
      .o_count (w_count)
   );

   // r_start is set exactly on the transition into ISSUE, so it equals
   // (state == ISSUE) while being a flop output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_start <= 1'b0;
         r_req   <= '0;
      end else begin
         r_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_req   <= w_head_req;
                  r_start <= 1'b1;
                  r_state <= ST_ISSUE;
               end else if (w_bypass) begin
                  r_req   <= w_enq_req;
                  r_start <= 1'b1;
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT:  if (!md_busy) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign md_start  = r_start;
   assign md_op     = r_req.op;
   assign md_a      = r_req.a;
   assign md_b      = r_req.b;
   assign occupancy = w_count;

   assign hilo_stall = hilo_req && ((w_count != '0) || (r_state != ST_IDLE) || md_busy);

endmodule
